// File: rtl/ysyx_24100006_axi_pkg.sv
// rtl/ysyx_24100006_axi_pkg.sv - shared constants and state encodings for the AXI crossbar
package ysyx_24100006_axi_pkg;

   localparam int NUM_SLAVES = 3;

   localparam logic [1:0] IDX_SRAM  = 2'd0;
   localparam logic [1:0] IDX_CLINT = 2'd1;
   localparam logic [1:0] IDX_UART  = 2'd2;
   localparam logic [1:0] IDX_ERR   = 2'd3;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA, R_ERR} rstate_t;
   typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wstate_t;

endpackage

// File: rtl/ysyx_24100006_xbar_decode.sv
// rtl/ysyx_24100006_xbar_decode.sv - address to slave index decoder
module ysyx_24100006_xbar_decode
   import ysyx_24100006_axi_pkg::*;
#(
   parameter logic [31:0] SRAM_BASE  = 32'h8000_0000,
   parameter logic [31:0] SRAM_MASK  = 32'hF800_0000,
   parameter logic [31:0] CLINT_BASE = 32'h0200_0000,
   parameter logic [31:0] CLINT_MASK = 32'hFFFF_0000,
   parameter logic [31:0] UART_BASE  = 32'h1000_0000,
   parameter logic [31:0] UART_MASK  = 32'hFFFF_F000
) (
   input  logic [31:0] addr,
   output logic [1:0]  idx
);

   // Earlier regions win when windows overlap.
   always_comb begin
      if ((addr & SRAM_MASK) == SRAM_BASE)
         idx = IDX_SRAM;
      else if ((addr & CLINT_MASK) == CLINT_BASE)
         idx = IDX_CLINT;
      else if ((addr & UART_MASK) == UART_BASE)
         idx = IDX_UART;
      else
         idx = IDX_ERR;
   end

endmodule

// File: rtl/ysyx_24100006_axi_xbar.sv
// rtl/ysyx_24100006_axi_xbar.sv - 1-master to 3-slave AXI crossbar with local DECERR
module ysyx_24100006_axi_xbar
   import ysyx_24100006_axi_pkg::*;
#(
   parameter logic [31:0] SRAM_BASE  = 32'h8000_0000,
   parameter logic [31:0] SRAM_MASK  = 32'hF800_0000,
   parameter logic [31:0] CLINT_BASE = 32'h0200_0000,
   parameter logic [31:0] CLINT_MASK = 32'hFFFF_0000,
   parameter logic [31:0] UART_BASE  = 32'h1000_0000,
   parameter logic [31:0] UART_MASK  = 32'hFFFF_F000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        m_axi_arvalid,
   output logic        m_axi_arready,
   input  logic [31:0] m_axi_araddr,
   input  logic [7:0]  m_axi_arlen,
   input  logic [2:0]  m_axi_arsize,
   output logic        m_axi_rvalid,
   input  logic        m_axi_rready,
   output logic [1:0]  m_axi_rresp,
   output logic [31:0] m_axi_rdata,
   output logic        m_axi_rlast,
   input  logic        m_axi_awvalid,
   output logic        m_axi_awready,
   input  logic [31:0] m_axi_awaddr,
   input  logic [7:0]  m_axi_awlen,
   input  logic [2:0]  m_axi_awsize,
   input  logic        m_axi_wvalid,
   output logic        m_axi_wready,
   input  logic [31:0] m_axi_wdata,
   input  logic [3:0]  m_axi_wstrb,
   input  logic        m_axi_wlast,
   output logic        m_axi_bvalid,
   input  logic        m_axi_bready,
   output logic [1:0]  m_axi_bresp,
   output logic [2:0]  s_axi_arvalid,
   input  logic [2:0]  s_axi_arready,
   output logic [31:0] s_axi_araddr,
   output logic [7:0]  s_axi_arlen,
   output logic [2:0]  s_axi_arsize,
   input  logic [2:0]  s_axi_rvalid,
   output logic [2:0]  s_axi_rready,
   input  logic [5:0]  s_axi_rresp,
   input  logic [95:0] s_axi_rdata,
   input  logic [2:0]  s_axi_rlast,
   output logic [2:0]  s_axi_awvalid,
   input  logic [2:0]  s_axi_awready,
   output logic [31:0] s_axi_awaddr,
   output logic [7:0]  s_axi_awlen,
   output logic [2:0]  s_axi_awsize,
   output logic [2:0]  s_axi_wvalid,
   input  logic [2:0]  s_axi_wready,
   output logic [31:0] s_axi_wdata,
   output logic [3:0]  s_axi_wstrb,
   output logic        s_axi_wlast,
   input  logic [2:0]  s_axi_bvalid,
   output logic [2:0]  s_axi_bready,
   input  logic [5:0]  s_axi_bresp
);

   logic [1:0] ar_dec, aw_dec;
   rstate_t    r_state;
   wstate_t    w_state;
   logic [1:0] r_idx, w_idx;
   logic [7:0] r_cnt;

   logic [2:0]  r_sel, w_sel;
   logic        sel_arready, sel_rvalid, sel_rlast;
   logic [1:0]  sel_rresp;
   logic [31:0] sel_rdata;
   logic        sel_awready, sel_wready, sel_bvalid;
   logic [1:0]  sel_bresp;

   ysyx_24100006_xbar_decode #(
      .SRAM_BASE(SRAM_BASE), .SRAM_MASK(SRAM_MASK), .CLINT_BASE(CLINT_BASE),
      .CLINT_MASK(CLINT_MASK), .UART_BASE(UART_BASE), .UART_MASK(UART_MASK)
   ) u_ar_decode (
      .addr(m_axi_araddr),
      .idx (ar_dec)
   );

   ysyx_24100006_xbar_decode #(
      .SRAM_BASE(SRAM_BASE), .SRAM_MASK(SRAM_MASK), .CLINT_BASE(CLINT_BASE),
      .CLINT_MASK(CLINT_MASK), .UART_BASE(UART_BASE), .UART_MASK(UART_MASK)
   ) u_aw_decode (
      .addr(m_axi_awaddr),
      .idx (aw_dec)
   );

   assign s_axi_araddr = m_axi_araddr;
   assign s_axi_arlen  = m_axi_arlen;
   assign s_axi_arsize = m_axi_arsize;
   assign s_axi_awaddr = m_axi_awaddr;
   assign s_axi_awlen  = m_axi_awlen;
   assign s_axi_awsize = m_axi_awsize;
   assign s_axi_wdata  = m_axi_wdata;
   assign s_axi_wstrb  = m_axi_wstrb;
   assign s_axi_wlast  = m_axi_wlast;

   // Latched index selects one slave's channel; ERR leaves the one-hot empty.
   always_comb begin
      r_sel       = '0;
      w_sel       = '0;
      sel_arready = 1'b0;
      sel_rvalid  = 1'b0;
      sel_rlast   = 1'b0;
      sel_rresp   = RESP_OKAY;
      sel_rdata   = '0;
      sel_awready = 1'b0;
      sel_wready  = 1'b0;
      sel_bvalid  = 1'b0;
      sel_bresp   = RESP_OKAY;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         if (r_idx == 2'(i)) begin
            r_sel[i]    = 1'b1;
            sel_arready = s_axi_arready[i];
            sel_rvalid  = s_axi_rvalid[i];
            sel_rlast   = s_axi_rlast[i];
            sel_rresp   = s_axi_rresp[2*i +: 2];
            sel_rdata   = s_axi_rdata[32*i +: 32];
         end
         if (w_idx == 2'(i)) begin
            w_sel[i]    = 1'b1;
            sel_awready = s_axi_awready[i];
            sel_wready  = s_axi_wready[i];
            sel_bvalid  = s_axi_bvalid[i];
            sel_bresp   = s_axi_bresp[2*i +: 2];
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= R_IDLE;
         r_idx   <= IDX_ERR;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            R_IDLE: if (m_axi_arvalid) begin
               r_idx   <= ar_dec;
               r_cnt   <= m_axi_arlen;
               r_state <= R_ADDR;
            end
            R_ADDR: begin
               if (r_idx == IDX_ERR)
                  r_state <= R_ERR;
               else if (m_axi_arvalid && m_axi_arready)
                  r_state <= R_DATA;
            end
            R_DATA: if (m_axi_rvalid && m_axi_rready && m_axi_rlast)
               r_state <= R_IDLE;
            R_ERR: if (m_axi_rready) begin
               if (r_cnt == 8'd0)
                  r_state <= R_IDLE;
               else
                  r_cnt <= r_cnt - 8'd1;
            end
            default: r_state <= R_IDLE;
         endcase
      end
   end

   always_comb begin
      m_axi_arready = 1'b0;
      s_axi_arvalid = '0;
      m_axi_rvalid  = 1'b0;
      m_axi_rresp   = RESP_OKAY;
      m_axi_rdata   = '0;
      m_axi_rlast   = 1'b0;
      s_axi_rready  = '0;
      case (r_state)
         R_ADDR: begin
            if (r_idx == IDX_ERR) begin
               m_axi_arready = 1'b1;
            end else begin
               s_axi_arvalid = r_sel & {3{m_axi_arvalid}};
               m_axi_arready = sel_arready;
            end
         end
         R_DATA: begin
            m_axi_rvalid = sel_rvalid;
            m_axi_rresp  = sel_rresp;
            m_axi_rdata  = sel_rdata;
            m_axi_rlast  = sel_rlast;
            s_axi_rready = r_sel & {3{m_axi_rready}};
         end
         R_ERR: begin
            m_axi_rvalid = 1'b1;
            m_axi_rresp  = RESP_DECERR;
            m_axi_rlast  = (r_cnt == 8'd0);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         w_state <= W_IDLE;
         w_idx   <= IDX_ERR;
      end else begin
         case (w_state)
            W_IDLE: if (m_axi_awvalid) begin
               w_idx   <= aw_dec;
               w_state <= W_ADDR;
            end
            W_ADDR: begin
               if (w_idx == IDX_ERR || (m_axi_awvalid && m_axi_awready))
                  w_state <= W_DATA;
            end
            W_DATA: if (m_axi_wvalid && m_axi_wready && m_axi_wlast)
               w_state <= W_RESP;
            W_RESP: if (m_axi_bvalid && m_axi_bready)
               w_state <= W_IDLE;
            default: w_state <= W_IDLE;
         endcase
      end
   end

   // Write data is held off until the address phase has completed.
   always_comb begin
      m_axi_awready = 1'b0;
      s_axi_awvalid = '0;
      m_axi_wready  = 1'b0;
      s_axi_wvalid  = '0;
      m_axi_bvalid  = 1'b0;
      m_axi_bresp   = RESP_OKAY;
      s_axi_bready  = '0;
      case (w_state)
         W_ADDR: begin
            if (w_idx == IDX_ERR) begin
               m_axi_awready = 1'b1;
            end else begin
               s_axi_awvalid = w_sel & {3{m_axi_awvalid}};
               m_axi_awready = sel_awready;
            end
         end
         W_DATA: begin
            if (w_idx == IDX_ERR) begin
               m_axi_wready = 1'b1;
            end else begin
               s_axi_wvalid = w_sel & {3{m_axi_wvalid}};
               m_axi_wready = sel_wready;
            end
         end
         W_RESP: begin
            if (w_idx == IDX_ERR) begin
               m_axi_bvalid = 1'b1;
               m_axi_bresp  = RESP_DECERR;
            end else begin
               m_axi_bvalid = sel_bvalid;
               m_axi_bresp  = sel_bresp;
               s_axi_bready = w_sel & {3{m_axi_bready}};
            end
         end
         default: ;
      endcase
   end

endmodule
